// File: rtl/chunked_serial_adder_pkg.sv
// chunked_serial_adder_pkg
// Shared definitions for the chunked serial adder:
//   - state_t: FSM state encoding (IDLE / BUSY / DONE)
//   - calc_nchunk: number of CHUNK-bit slices in a WIDTH-bit operand
//   - calc_idx_w:  width of the chunk index counter
package chunked_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Wide enough to hold NCHUNK itself, not only NCHUNK-1.
    function automatic int calc_idx_w(input int nchunk);
        return $clog2(nchunk + 1);
    endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// chunked_serial_adder_if
// Operand/result handshake bundle for chunked_serial_adder.
//   in_valid/in_ready  : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready: result handshake (sum, cout)
// Modports:
//   master - producer/consumer side (drives operands, accepts results)
//   slave  - the adder itself
// Optional macro CHUNKED_SERIAL_ADDER_SUB_EN adds the 1-bit 'sub' operand.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// chunk_adder
// Purely combinational CHUNK-bit ripple-carry adder.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   sum  : CHUNK-bit sum
//   cout : carry out of the top bit
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[CHUNK];
endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle unsigned adder: WIDTH-bit sum computed CHUNK bits per clock,
// carry registered between chunks. Operands accepted in IDLE, NCHUNK BUSY
// cycles, result presented in DONE until out_ready.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - chunked_serial_adder_if.slave (operand and result handshakes)
// Parameters: WIDTH (multiple of CHUNK), CHUNK (1..WIDTH).
// Optional macro CHUNKED_SERIAL_ADDER_SUB_EN: adds 'sub'; when set, b is
// inverted at capture and the initial carry forced to 1 (a - b, cout = no borrow).
module chunked_serial_adder
    import chunked_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chunked_serial_adder_if.slave  bus
);
    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(NCHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              b_inv;
    logic              carry_init;

    // Operand conditioning at capture time.
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    assign b_inv      = bus.sub;
    assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_inv      = 1'b0;
    assign carry_init = bus.cin;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_reg[idx_reg*CHUNK +: CHUNK]),
        .b    (b_reg[idx_reg*CHUNK +: CHUNK]),
        .cin  (carry_reg),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_reg        <= bus.a;
                        b_reg        <= b_inv ? ~bus.b : bus.b;
                        carry_reg    <= carry_init;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    sum_reg[idx_reg*CHUNK +: CHUNK] <= chunk_sum;
                    carry_reg <= chunk_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == IDXW'(NCHUNK - 1)) begin
                        cout_reg      <= chunk_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low here: no same-cycle accept on release.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder. Three instances (CHUNK = 2,
// 1, 8 at WIDTH = 8) share reset and operands; each result is compared with
// plain a+b+cin arithmetic and the expected latency WIDTH/CHUNK.
module tb_chunked_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    chunked_serial_adder_if #(.WIDTH(W)) if2 ();
    chunked_serial_adder_if #(.WIDTH(W)) if1 ();
    chunked_serial_adder_if #(.WIDTH(W)) if8 ();

    chunked_serial_adder #(.WIDTH(W), .CHUNK(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    chunked_serial_adder #(.WIDTH(W), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    chunked_serial_adder #(.WIDTH(W), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    // Shared operand drive, per-instance handshake drive.
    logic [W-1:0] drv_a, drv_b;
    logic         drv_cin, drv_sub;
    logic [2:0]   drv_valid, drv_ready;

    assign if2.a = drv_a;  assign if1.a = drv_a;  assign if8.a = drv_a;
    assign if2.b = drv_b;  assign if1.b = drv_b;  assign if8.b = drv_b;
    assign if2.cin = drv_cin; assign if1.cin = drv_cin; assign if8.cin = drv_cin;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    assign if2.sub = drv_sub; assign if1.sub = drv_sub; assign if8.sub = drv_sub;
`endif
    assign if2.in_valid = drv_valid[0]; assign if1.in_valid = drv_valid[1]; assign if8.in_valid = drv_valid[2];
    assign if2.out_ready = drv_ready[0]; assign if1.out_ready = drv_ready[1]; assign if8.out_ready = drv_ready[2];

    // Observation vectors, index 0: CHUNK=2, 1: CHUNK=1, 2: CHUNK=8.
    logic [2:0]   ov_w, ir_w, co_w;
    logic [W-1:0] sum_w [3];
    assign ov_w = {if8.out_valid, if1.out_valid, if2.out_valid};
    assign ir_w = {if8.in_ready, if1.in_ready, if2.in_ready};
    assign co_w = {if8.cout, if1.cout, if2.cout};
    assign sum_w[0] = if2.sum;
    assign sum_w[1] = if1.sum;
    assign sum_w[2] = if8.sum;

    int exp_lat [3] = '{4, 8, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        if (ms)
            return {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One transaction on the instances in 'mask'. hold=1 keeps out_ready low
    // until well after the slowest result, then releases it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [2:0] mask, input logic hold);
        logic [2:0]   seen;
        int           lat  [3];
        logic [W-1:0] gsum [3];
        logic         gco  [3];
        logic [W:0]   expv;
        logic         eff_sub;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        eff_sub = ts;
`else
        eff_sub = 1'b0;
`endif
        expv = model(ta, tb, tc, eff_sub);
        seen = '0;
        for (int i = 0; i < 3; i++) begin lat[i] = 0; gsum[i] = '0; gco[i] = 1'b0; end

        @(negedge clk);
        for (int i = 0; i < 3; i++)
            if (mask[i]) check($sformatf("ready_before_i%0d", i), 32'(ir_w[i]), 32'd1);
        drv_a = ta; drv_b = tb; drv_cin = tc; drv_sub = ts;
        drv_valid = mask;
        drv_ready = hold ? 3'b000 : 3'b111;
        @(posedge clk); #1;
        // Operand lines now change freely; the adders must ignore them.
        drv_valid = '0;
        drv_a = W'($urandom); drv_b = W'($urandom);
        drv_cin = 1'($urandom); drv_sub = 1'($urandom);
        for (int i = 0; i < 3; i++)
            if (mask[i]) check($sformatf("ready_low_i%0d", i), 32'(ir_w[i]), 32'd0);

        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (mask[i] && seen[i] && hold) begin
                    check($sformatf("hold_sum_i%0d", i), 32'(sum_w[i]), 32'(gsum[i]));
                    check($sformatf("hold_ready_i%0d", i), 32'(ir_w[i]), 32'd0);
                end
                if (mask[i] && !seen[i] && ov_w[i]) begin
                    seen[i] = 1'b1; lat[i] = k; gsum[i] = sum_w[i]; gco[i] = co_w[i];
                end
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                check($sformatf("seen_i%0d", i), 32'(seen[i]), 32'd1);
                check($sformatf("latency_i%0d", i), 32'(lat[i]), 32'(exp_lat[i]));
                check($sformatf("sum_i%0d a=%0h b=%0h", i, ta, tb), 32'(gsum[i]), 32'(expv[W-1:0]));
                check($sformatf("cout_i%0d a=%0h b=%0h", i, ta, tb), 32'(gco[i]), 32'(expv[W]));
            end
        end

        if (hold) begin
            for (int i = 0; i < 3; i++)
                if (mask[i]) check($sformatf("held_valid_i%0d", i), 32'(ov_w[i]), 32'd1);
            @(negedge clk);
            drv_ready = 3'b111;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                check($sformatf("released_valid_i%0d", i), 32'(ov_w[i]), 32'd0);
                check($sformatf("released_ready_i%0d", i), 32'(ir_w[i]), 32'd1);
            end
        end
        $display("op a=%02h b=%02h cin=%0b sub=%0b mask=%03b hold=%0b exp=%0b/%02h",
                 ta, tb, tc, eff_sub, mask, hold, expv[W], expv[W-1:0]);
    endtask

    // Three back-to-back operations on the CHUNK=2 instance with out_ready high.
    task automatic run_b2b();
        logic [W-1:0] oa [3] = '{8'h01, 8'h80, 8'h7F};
        logic [W-1:0] ob [3] = '{8'h01, 8'h80, 8'h00};
        logic         oc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{8'h02, 8'h00, 8'h80};
        logic         ec [3] = '{1'b0, 1'b1, 1'b0};
        int issued, got;
        int out_cyc [3];
        logic [W-1:0] rs [3];
        logic         rc [3];
        issued = 0; got = 0;
        for (int i = 0; i < 3; i++) begin out_cyc[i] = 0; rs[i] = '0; rc[i] = 1'b0; end
        drv_ready = 3'b111;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ov_w[0] && got < 3) begin
                out_cyc[got] = cyc; rs[got] = sum_w[0]; rc[got] = co_w[0]; got++;
            end
            if (ir_w[0] && issued < 3) begin
                drv_a = oa[issued]; drv_b = ob[issued]; drv_cin = oc[issued]; drv_sub = 1'b0;
                drv_valid = 3'b001;
                issued++;
            end else begin
                drv_valid = 3'b000;
            end
        end
        check("b2b_results", 32'(got), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_sum_%0d", i), 32'(rs[i]), 32'(es[i]));
            check($sformatf("b2b_cout_%0d", i), 32'(rc[i]), 32'(ec[i]));
            $display("b2b %0d a=%02h b=%02h cin=%0b got=%0b/%02h at cycle %0d",
                     i, oa[i], ob[i], oc[i], rc[i], rs[i], out_cyc[i]);
        end
        check("b2b_spacing_01", 32'(out_cyc[1] - out_cyc[0]), 32'd6);
        check("b2b_spacing_12", 32'(out_cyc[2] - out_cyc[1]), 32'd6);
    endtask

    initial begin
        logic saw_valid;
        checks = 0; errors = 0; cyc = 0;
        drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0;
        drv_valid = '0; drv_ready = 3'b111;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready_i%0d", i), 32'(ir_w[i]), 32'd1);
            check($sformatf("rst_valid_i%0d", i), 32'(ov_w[i]), 32'd0);
            check($sformatf("rst_sum_i%0d", i), 32'(sum_w[i]), 32'd0);
            check($sformatf("rst_cout_i%0d", i), 32'(co_w[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-BUSY (CHUNK=2, CHUNK=1) and mid-DONE (CHUNK=8).
        @(negedge clk);
        drv_a = 8'h12; drv_b = 8'h34; drv_cin = 1'b0; drv_sub = 1'b0;
        drv_valid = 3'b111; drv_ready = 3'b000;
        @(posedge clk); #1;
        drv_valid = 3'b000;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_valid_i%0d", i), 32'(ov_w[i]), 32'd0);
            check($sformatf("abort_sum_i%0d", i), 32'(sum_w[i]), 32'd0);
            check($sformatf("abort_cout_i%0d", i), 32'(co_w[i]), 32'd0);
            check($sformatf("abort_ready_i%0d", i), 32'(ir_w[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drv_ready = 3'b111;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov_w != 3'b000) saw_valid = 1'b1;
        end
        check("abort_no_result", 32'(saw_valid), 32'd0);
        $display("abort a=12 b=34 mid-operation, valid seen later=%0b", saw_valid);

        // Directed cases.
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 3'b111, 1'b0);   // full carry ripple
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 3'b111, 1'b1);   // backpressure
        run_op(8'hC3, 8'h3D, 1'b0, 1'b0, 3'b111, 1'b0);   // parameter sweep
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 3'b111, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 3'b111, 1'b0);
        run_b2b();
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 3'b111, 1'b0);
        run_op(8'h07, 8'h05, 1'b0, 1'b1, 3'b111, 1'b0);
`endif

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   3'b111, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
